// File: rtl/controle_multiciclo_pkg.sv
// Shared processor definitions: opcode/funct constants, ALU operation codes,
// control-FSM states and instruction-class decode helpers.
package pacote_processador;

    localparam logic [6:0] OPC_REG    = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_ANDI = 3'b111;
    localparam logic [2:0] F3_HALF = 3'b001;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [6:0] F7_ADD  = 7'b0000000;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef enum logic [2:0] {
        ESPERA, DECODIFICA, EXECUTA, MEMORIA, ESCRITA, DESVIO
    } estado_t;

    typedef enum logic [2:0] {
        C_ADD, C_OR, C_SLL, C_ANDI, C_LH, C_SH, C_BNE, C_INVALIDA
    } classe_t;

    typedef enum logic [1:0] {
        FMT_I, FMT_S, FMT_B
    } formato_t;

    function automatic classe_t classifica(input logic [6:0] opcode,
                                           input logic [2:0] f3,
                                           input logic [6:0] f7);
        classe_t c;
        c = C_INVALIDA;
        case (opcode)
            OPC_REG: begin
                if (f3 == F3_ADD && f7 == F7_ADD) c = C_ADD;
                else if (f3 == F3_OR)             c = C_OR;
                else if (f3 == F3_SLL)            c = C_SLL;
            end
            OPC_IMM:    if (f3 == F3_ANDI) c = C_ANDI;
            OPC_LOAD:   if (f3 == F3_HALF) c = C_LH;
            OPC_STORE:  if (f3 == F3_HALF) c = C_SH;
            OPC_BRANCH: if (f3 == F3_BNE)  c = C_BNE;
            default:    c = C_INVALIDA;
        endcase
        return c;
    endfunction

    function automatic logic [3:0] op_da_classe(input classe_t c);
        case (c)
            C_OR:    return ALU_OR;
            C_SLL:   return ALU_SLL;
            C_ANDI:  return ALU_AND;
            C_BNE:   return ALU_SUB;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic sel_da_classe(input classe_t c);
        return (c == C_ANDI) || (c == C_LH) || (c == C_SH);
    endfunction

    function automatic formato_t formato_da_classe(input classe_t c);
        case (c)
            C_SH:    return FMT_S;
            C_BNE:   return FMT_B;
            default: return FMT_I;
        endcase
    endfunction

endpackage

// File: rtl/controle_multiciclo_if.sv
// Fetch/memory handshake and decoded control bundle between the control unit
// and its neighbours (fetch, ALU, register file, data memory, PC logic).
interface controle_multiciclo_if;
    logic [31:0] instrucao;
    logic        instrucao_valida;
    logic        instrucao_pronta;
    logic        mem_pronto;
    logic [3:0]  resultado_alu_control;
    logic        sel_alu_imediato;
    logic [31:0] imediato;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        escreve_reg;
    logic        mem_para_reg;
    logic        le_mem;
    logic        escreve_mem;
    logic        avalia_desvio;
    logic        instrucao_invalida;
    logic [31:0] contador_instrucoes;

    modport slave (
        input  instrucao, instrucao_valida, mem_pronto,
        output instrucao_pronta, resultado_alu_control, sel_alu_imediato,
               imediato, rs1, rs2, rd, escreve_reg, mem_para_reg, le_mem,
               escreve_mem, avalia_desvio, instrucao_invalida,
               contador_instrucoes
    );

    modport master (
        output instrucao, instrucao_valida, mem_pronto,
        input  instrucao_pronta, resultado_alu_control, sel_alu_imediato,
               imediato, rs1, rs2, rd, escreve_reg, mem_para_reg, le_mem,
               escreve_mem, avalia_desvio, instrucao_invalida,
               contador_instrucoes
    );
endinterface

// File: rtl/controle_multiciclo_gerador_imediato.sv
// Sign-extended I/S/B immediate builder; fed with instruction bits [31:20]
// and [11:7], which together hold every immediate bit of these formats.
module gerador_imediato
    import pacote_processador::*;
(
    input  logic [11:0] campo_alto,
    input  logic [4:0]  campo_baixo,
    input  formato_t    formato,
    output logic [31:0] imediato
);
    always_comb begin
        imediato = {{20{campo_alto[11]}}, campo_alto};
        case (formato)
            FMT_S: imediato = {{20{campo_alto[11]}}, campo_alto[11:5], campo_baixo};
            FMT_B: imediato = {{19{campo_alto[11]}}, campo_alto[11], campo_baixo[0],
                               campo_alto[10:5], campo_baixo[4:1], 1'b0};
            default: ;
        endcase
    end
endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle RV32-subset control unit: accepts one instruction, decodes it and
// sequences execute, memory, write-back and branch phases; counts retirements.
module controle_multiciclo
    import pacote_processador::*;
(
    input logic                  clock,
    input logic                  reset,
    controle_multiciclo_if.slave bus
);
    estado_t     estado_q, estado_d;
    logic [31:0] ir_q, ir_d;
    logic [3:0]  op_q, op_d;
    logic        sel_q, sel_d;
    logic [31:0] imediato_q, imediato_d;
    logic        pronta_q, pronta_d;
    logic        escreve_reg_q, escreve_reg_d;
    logic        mem_para_reg_q, mem_para_reg_d;
    logic        le_mem_q, le_mem_d;
    logic        escreve_mem_q, escreve_mem_d;
    logic        avalia_q, avalia_d;
    logic        invalida_q, invalida_d;
    logic [31:0] contador_q, contador_d;

    classe_t     classe_entrada, classe_ir;
    logic [31:0] imm_gerado;
    logic        rd_nao_zero;

    // Decoded fields are computed from the incoming word at the accept edge so
    // they are already stable during DECODIFICA and held until ESPERA.
    assign classe_entrada = classifica(bus.instrucao[6:0], bus.instrucao[14:12], bus.instrucao[31:25]);
    assign classe_ir      = classifica(ir_q[6:0], ir_q[14:12], ir_q[31:25]);
    assign rd_nao_zero    = |ir_q[11:7];

    gerador_imediato u_gerador_imediato (
        .campo_alto  (bus.instrucao[31:20]),
        .campo_baixo (bus.instrucao[11:7]),
        .formato     (formato_da_classe(classe_entrada)),
        .imediato    (imm_gerado)
    );

    always_comb begin
        estado_d       = estado_q;
        ir_d           = ir_q;
        op_d           = op_q;
        sel_d          = sel_q;
        imediato_d     = imediato_q;
        pronta_d       = pronta_q;
        escreve_reg_d  = escreve_reg_q;
        mem_para_reg_d = mem_para_reg_q;
        le_mem_d       = le_mem_q;
        escreve_mem_d  = escreve_mem_q;
        avalia_d       = avalia_q;
        invalida_d     = 1'b0;
        contador_d     = contador_q;

        case (estado_q)
            ESPERA: begin
                if (bus.instrucao_valida) begin
                    ir_d       = bus.instrucao;
                    op_d       = op_da_classe(classe_entrada);
                    sel_d      = sel_da_classe(classe_entrada);
                    imediato_d = imm_gerado;
                    invalida_d = (classe_entrada == C_INVALIDA);
                    pronta_d   = 1'b0;
                    estado_d   = DECODIFICA;
                end
            end
            DECODIFICA: begin
                if (classe_ir == C_INVALIDA) begin
                    pronta_d = 1'b1;
                    estado_d = ESPERA;
                end else begin
                    estado_d = EXECUTA;
                end
            end
            EXECUTA: begin
                case (classe_ir)
                    C_LH: begin
                        le_mem_d       = 1'b1;
                        mem_para_reg_d = 1'b1;
                        estado_d       = MEMORIA;
                    end
                    C_SH: begin
                        escreve_mem_d = 1'b1;
                        estado_d      = MEMORIA;
                    end
                    C_BNE: begin
                        avalia_d = 1'b1;
                        estado_d = DESVIO;
                    end
                    default: begin
                        escreve_reg_d  = rd_nao_zero;
                        mem_para_reg_d = 1'b0;
                        estado_d       = ESCRITA;
                    end
                endcase
            end
            MEMORIA: begin
                if (bus.mem_pronto) begin
                    le_mem_d      = 1'b0;
                    escreve_mem_d = 1'b0;
                    if (classe_ir == C_LH) begin
                        escreve_reg_d = rd_nao_zero;
                        estado_d      = ESCRITA;
                    end else begin
                        contador_d = contador_q + 32'd1;
                        pronta_d   = 1'b1;
                        estado_d   = ESPERA;
                    end
                end
            end
            ESCRITA: begin
                escreve_reg_d  = 1'b0;
                mem_para_reg_d = 1'b0;
                contador_d     = contador_q + 32'd1;
                pronta_d       = 1'b1;
                estado_d       = ESPERA;
            end
            DESVIO: begin
                avalia_d   = 1'b0;
                contador_d = contador_q + 32'd1;
                pronta_d   = 1'b1;
                estado_d   = ESPERA;
            end
            default: begin
                pronta_d = 1'b1;
                estado_d = ESPERA;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q       <= ESPERA;
            ir_q           <= '0;
            op_q           <= ALU_ADD;
            sel_q          <= 1'b0;
            imediato_q     <= '0;
            pronta_q       <= 1'b1;
            escreve_reg_q  <= 1'b0;
            mem_para_reg_q <= 1'b0;
            le_mem_q       <= 1'b0;
            escreve_mem_q  <= 1'b0;
            avalia_q       <= 1'b0;
            invalida_q     <= 1'b0;
            contador_q     <= '0;
        end else begin
            estado_q       <= estado_d;
            ir_q           <= ir_d;
            op_q           <= op_d;
            sel_q          <= sel_d;
            imediato_q     <= imediato_d;
            pronta_q       <= pronta_d;
            escreve_reg_q  <= escreve_reg_d;
            mem_para_reg_q <= mem_para_reg_d;
            le_mem_q       <= le_mem_d;
            escreve_mem_q  <= escreve_mem_d;
            avalia_q       <= avalia_d;
            invalida_q     <= invalida_d;
            contador_q     <= contador_d;
        end
    end

    assign bus.instrucao_pronta      = pronta_q;
    assign bus.resultado_alu_control = op_q;
    assign bus.sel_alu_imediato      = sel_q;
    assign bus.imediato              = imediato_q;
    assign bus.rs1                   = ir_q[19:15];
    assign bus.rs2                   = ir_q[24:20];
    assign bus.rd                    = ir_q[11:7];
    assign bus.escreve_reg           = escreve_reg_q;
    assign bus.mem_para_reg          = mem_para_reg_q;
    assign bus.le_mem                = le_mem_q;
    assign bus.escreve_mem           = escreve_mem_q;
    assign bus.avalia_desvio         = avalia_q;
    assign bus.instrucao_invalida    = invalida_q;
    assign bus.contador_instrucoes   = contador_q;
endmodule
